// File: rtl/mips_pkg.sv
// mips_pkg: ISA-fixed encodings shared by the multicycle MIPS controller.
package mips_pkg;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;
endpackage

// File: rtl/alu_dec.sv
// alu_dec: R-type funct to ALUControl, with a flag marking supported funct codes.
module alu_dec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);
    always_comb begin
        valid       = 1'b1;
        alu_control = ALU_ADD;
        case (funct)
            F_ADD:   alu_control = ALU_ADD;
            F_SUB:   alu_control = ALU_SUB;
            F_AND:   alu_control = ALU_AND;
            F_OR:    alu_control = ALU_OR;
            F_SLT:   alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main controller, a Moore FSM on Op plus the funct decoder.
module mc_control
    import mips_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllInstr
);
    state_t     state, next;
    logic [2:0] alu_ctl;
    logic       funct_ok, pc_write, branch, ill;

    alu_dec u_alu_dec (.funct(Funct), .alu_control(alu_ctl), .valid(funct_ok));

    // An illegal instruction is the only way DECODE falls straight back to FETCH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FETCH;
            ill   <= 1'b0;
        end else begin
            state <= next;
            ill   <= (state == DECODE) && (next == FETCH);
        end
    end

    assign IllInstr = ill;
    assign PCEn     = pc_write | (branch & Zero);

    always_comb begin
        next       = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUControl = ALU_ADD;
        PCSrc      = PC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB  = SRCB_4;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
                next     = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM2;
                case (Op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = funct_ok ? EXECUTE : FETCH;
                    OP_BEQ:       next = BRANCH;
                    OP_ADDI:      next = ADDIEXEC;
                    OP_J:         next = JUMP;
                    default:      next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = (Op == OP_LW) ? MEMRD : (Op == OP_SW) ? MEMWR : FETCH;
            end
            MEMRD: begin
                IorD = 1'b1;
                next = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_ctl;
                next       = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUOUT;
                branch     = 1'b1;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                next    = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCSrc    = PC_JUMP;
                pc_write = 1'b1;
            end
            default: ALUControl = 3'b000;
        endcase
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table of instructions expanded into per-cycle expected outputs on a scoreboard queue.
module tb_mc_control;
    logic       CLK, RST, Zero;
    logic [5:0] Op, Funct;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, IllInstr;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [15:0] obs;

    mc_control dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .IllInstr(IllInstr)
    );

    assign obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, IllInstr};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef enum int {K_LW, K_SW, K_R, K_ADDI, K_BEQ, K_J, K_ILL} kind_t;
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        kind_t      kind;
        logic [2:0] alu;
    } vec_t;
    typedef struct {
        logic [15:0] v;
        string       n;
    } exp_t;

    exp_t q[$];
    vec_t vecs[14];
    int   checks = 0, failures = 0;
    logic prev_ill = 1'b0;

    function automatic logic [15:0] e(logic iord, logic mw, logic ir, logic rd, logic m2r,
                                      logic rw, logic sa, logic [1:0] sb, logic [2:0] ac,
                                      logic [1:0] ps, logic pcen, logic il);
        return {iord, mw, ir, rd, m2r, rw, sa, sb, ac, ps, pcen, il};
    endfunction

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] v, input string n);
        exp_t x;
        x.v = v;
        x.n = n;
        q.push_back(x);
    endtask

    task automatic push_instr(input vec_t t, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        push(e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,prev_ill), {s, "_fetch"});
        push(e(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0), {s, "_decode"});
        prev_ill = 1'b0;
        case (t.kind)
            K_LW: begin
                push(e(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0), {s, "_memadr"});
                push(e(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0), {s, "_memrd"});
                push(e(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0), {s, "_memwb"});
            end
            K_SW: begin
                push(e(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0), {s, "_memadr"});
                push(e(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0), {s, "_memwr"});
            end
            K_R: begin
                push(e(0,0,0,0,0,0,1,2'b00,t.alu,2'b00,0,0), {s, "_execute"});
                push(e(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0), {s, "_aluwb"});
            end
            K_ADDI: begin
                push(e(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0), {s, "_addiexec"});
                push(e(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0), {s, "_addiwb"});
            end
            K_BEQ: push(e(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,t.zero,0), {s, "_branch"});
            K_J:   push(e(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0), {s, "_jump"});
            default: prev_ill = 1'b1;
        endcase
    endtask

    task automatic drain();
        exp_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            check(x.n, obs, x.v);
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, K_LW,   3'b010};
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, K_SW,   3'b010};
        vecs[2]  = '{6'b000000, 6'b100000, 1'b0, K_R,    3'b010};
        vecs[3]  = '{6'b000000, 6'b100010, 1'b0, K_R,    3'b110};
        vecs[4]  = '{6'b000000, 6'b100100, 1'b0, K_R,    3'b000};
        vecs[5]  = '{6'b000000, 6'b100101, 1'b0, K_R,    3'b001};
        vecs[6]  = '{6'b000000, 6'b101010, 1'b0, K_R,    3'b111};
        vecs[7]  = '{6'b001000, 6'b111111, 1'b0, K_ADDI, 3'b010};
        vecs[8]  = '{6'b000100, 6'b000000, 1'b1, K_BEQ,  3'b010};
        vecs[9]  = '{6'b000100, 6'b000000, 1'b0, K_BEQ,  3'b010};
        vecs[10] = '{6'b000010, 6'b000000, 1'b1, K_J,    3'b010};
        vecs[11] = '{6'b111111, 6'b100000, 1'b0, K_ILL,  3'b010};
        vecs[12] = '{6'b000000, 6'b000000, 1'b0, K_ILL,  3'b010};
        vecs[13] = '{6'b100011, 6'b000000, 1'b0, K_LW,   3'b010};

        RST = 1'b0; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
        #2 RST = 1'b1;
        #1 check("reset_async", obs, e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
        @(posedge CLK); @(posedge CLK); #1;
        check("reset_held", obs, e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
        RST = 1'b0;

        foreach (vecs[i]) begin
            Op = vecs[i].op; Funct = vecs[i].funct; Zero = vecs[i].zero;
            push_instr(vecs[i], i);
            drain();
        end

        Op = 6'b101011; Funct = 6'b0; Zero = 1'b0;
        push(e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,prev_ill), "sw_rst_fetch");
        push(e(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0), "sw_rst_decode");
        prev_ill = 1'b0;
        drain();
        check("sw_rst_memadr", obs, e(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
        #2 RST = 1'b1;
        #1 check("sw_rst_mid", obs, e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
        @(posedge CLK); #1;
        check("sw_rst_nomw", obs, e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
        RST = 1'b0;
        Op = vecs[0].op;
        push_instr(vecs[0], 99);
        drain();
        check("final_fetch", obs, e(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
